// File: rtl/mctl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// ALU operations, instruction classes and datapath mux encodings.
// Latency: n/a (definitions only). Backpressure: n/a.
package mctl_pkg;

  // Opcode field values (ins[INS_W-1 -: 6])
  localparam logic [5:0] OP_ANDR = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NORR = 6'b100110;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_NOTR = 6'b000100;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [4:0] {
    ALU_ADD     = 5'd0,
    ALU_AND     = 5'd1,
    ALU_NOR     = 5'd2,
    ALU_ROL     = 5'd3,
    ALU_ROR     = 5'd4,
    ALU_CMP_LEU = 5'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    IC_MEM, IC_ALU, IC_BRANCH, IC_JUMP, IC_ILLEGAL
  } iclass_t;

  // pc_src encodings
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // reg_dst encodings
  localparam logic [1:0] REGDST_RT   = 2'd0;
  localparam logic [1:0] REGDST_RD   = 2'd1;
  localparam logic [1:0] REGDST_LINK = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] ASRCB_REG  = 2'd0;
  localparam logic [1:0] ASRCB_FOUR = 2'd1;
  localparam logic [1:0] ASRCB_IMM  = 2'd2;

  typedef struct packed {
    iclass_t iclass;
    logic    is_lw;    // memory class: load (else store)
    logic    is_jal;   // jump class: jal (else jr)
    logic    is_nori;  // ALU class: immediate operand, writes rt
    alu_op_t alu_op;   // operation used in EXEC
  } dec_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> instruction register / datapath / memory signal bundle.
// master: control unit (drives strobes, reads ins/mem_ready/alu_leu);
// slave: datapath and memory side. Latency/backpressure: n/a (wires only).
interface multicycle_control_if #(
  parameter int INS_W = 32,
  parameter int ALU_W = 5,
  parameter int CNT_W = 16
);
  import mctl_pkg::*;

  logic [INS_W-1:0] ins;
  logic             mem_ready;
  logic             alu_leu;
  logic             mem_req;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic [1:0]       reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [ALU_W-1:0] alu_control;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] instr_retired;
  logic             illegal_op;

  modport master (
    input  ins, mem_ready, alu_leu,
    output mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write,
           mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_retired, illegal_op
  );

  modport slave (
    output ins, mem_ready, alu_leu,
    input  mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write,
           mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_retired, illegal_op
  );
endinterface

// File: rtl/mctl_decode.sv
// Opcode -> instruction class, sub-kind flags and EXEC-stage ALU operation.
// Latency: combinational. Backpressure: none.
// Ports: opcode in (6b), dec out (dec_t). Unknown opcodes give IC_ILLEGAL.
module mctl_decode
  import mctl_pkg::*;
(
  input  logic [5:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec.iclass  = IC_ILLEGAL;
    dec.is_lw   = 1'b0;
    dec.is_jal  = 1'b0;
    dec.is_nori = 1'b0;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OP_LW:   begin dec.iclass = IC_MEM; dec.is_lw = 1'b1; end
      OP_SW:   dec.iclass = IC_MEM;
      OP_ANDR: begin dec.iclass = IC_ALU; dec.alu_op = ALU_AND; end
      OP_NORR: begin dec.iclass = IC_ALU; dec.alu_op = ALU_NOR; end
      OP_NORI: begin dec.iclass = IC_ALU; dec.alu_op = ALU_NOR; dec.is_nori = 1'b1; end
      // NOT rs is executed as NOR(rs, rs); the datapath routes rs to both inputs
      OP_NOTR: begin dec.iclass = IC_ALU; dec.alu_op = ALU_NOR; end
      OP_ROLV: begin dec.iclass = IC_ALU; dec.alu_op = ALU_ROL; end
      OP_RORV: begin dec.iclass = IC_ALU; dec.alu_op = ALU_ROR; end
      OP_BLEU: begin dec.iclass = IC_BRANCH; dec.alu_op = ALU_CMP_LEU; end
      OP_JR:   dec.iclass = IC_JUMP;
      OP_JAL:  begin dec.iclass = IC_JUMP; dec.is_jal = 1'b1; end
      default: dec.iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback strobes plus
// retired-instruction counter. Latency: lw 5, sw 4, ALU 4, bleu 3, jr/jal 3
// cycles at zero wait. Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready.
// Ports: clk, reset (sync, active-high), bus (multicycle_control_if.master).
// Option: MCTL_ILLEGAL_TRAP_EN sends unknown opcodes to a sticky TRAP state and
// raises illegal_op; without it they retire as NOPs and illegal_op is 0.
module multicycle_control
  import mctl_pkg::*;
#(
  parameter int INS_W = 32,
  parameter int ALU_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_t     state, state_nxt;
  dec_t       dec;
  logic       mem_req_q, mem_write_q, i_or_d_q, pc_write_q, reg_write_q;
  logic       mem_to_reg_q, alu_src_a_q;
  logic [1:0] reg_dst_q, alu_src_b_q, pc_src_q;
  alu_op_t    alu_op_q;
  logic [CNT_W-1:0] cnt_q;
  logic       fetch_ack;
  logic       retire;
  logic       unused_ins_lo;

  mctl_decode u_decode (
    .opcode (bus.ins[INS_W-1 -: 6]),
    .dec    (dec)
  );

  // Operand fields are consumed by the datapath, not here.
  assign unused_ins_lo = ^bus.ins[INS_W-7:0];

  // mem_req_q is low in the first FETCH cycle after reset, so a stray
  // mem_ready there is ignored rather than taken as a completed fetch.
  assign fetch_ack = (state == S_FETCH) && mem_req_q && bus.mem_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (fetch_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (dec.iclass)
          IC_MEM:    state_nxt = S_MEMADDR;
          IC_ALU:    state_nxt = S_EXEC;
          IC_BRANCH: state_nxt = S_BRANCH;
          IC_JUMP:   state_nxt = S_JUMP;
`ifdef MCTL_ILLEGAL_TRAP_EN
          default:   state_nxt = S_TRAP;
`else
          default:   state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR:  state_nxt = dec.is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
      S_EXEC:     state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  assign retire = (state_nxt == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);

  // Outputs are registered from the state being entered, so they are a pure
  // function of the current state during each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_a_q  <= 1'b0;
      reg_dst_q    <= REGDST_RT;
      alu_src_b_q  <= ASRCB_REG;
      pc_src_q     <= PCSRC_ALU;
      alu_op_q     <= ALU_ADD;
      cnt_q        <= '0;
    end else begin
      state        <= state_nxt;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      i_or_d_q     <= 1'b0;
      pc_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_a_q  <= 1'b0;
      reg_dst_q    <= REGDST_RT;
      alu_src_b_q  <= ASRCB_REG;
      pc_src_q     <= PCSRC_ALU;
      alu_op_q     <= ALU_ADD;
      case (state_nxt)
        S_FETCH: begin
          mem_req_q   <= 1'b1;
          alu_src_b_q <= ASRCB_FOUR;
        end
        S_MEMADDR: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= ASRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req_q <= 1'b1;
          i_or_d_q  <= 1'b1;
        end
        S_MEMWB: begin
          reg_write_q  <= 1'b1;
          mem_to_reg_q <= 1'b1;
        end
        S_MEMWRITE: begin
          mem_req_q   <= 1'b1;
          mem_write_q <= 1'b1;
          i_or_d_q    <= 1'b1;
        end
        S_EXEC: begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= dec.is_nori ? ASRCB_IMM : ASRCB_REG;
          alu_op_q    <= dec.alu_op;
        end
        S_ALUWB: begin
          reg_write_q <= 1'b1;
          reg_dst_q   <= dec.is_nori ? REGDST_RT : REGDST_RD;
        end
        S_BRANCH: begin
          alu_src_a_q <= 1'b1;
          alu_op_q    <= ALU_CMP_LEU;
          pc_src_q    <= PCSRC_BRANCH;
        end
        S_JUMP: begin
          pc_write_q  <= 1'b1;
          pc_src_q    <= dec.is_jal ? PCSRC_JUMP : PCSRC_RS;
          reg_write_q <= dec.is_jal;
          reg_dst_q   <= dec.is_jal ? REGDST_LINK : REGDST_RT;
        end
        default: ;
      endcase
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef MCTL_ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk) begin
    if (reset)                                           ill_q <= 1'b0;
    else if (state == S_DECODE && state_nxt == S_TRAP)   ill_q <= 1'b1;
  end
  assign bus.illegal_op = ill_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

  assign bus.mem_req       = mem_req_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.i_or_d        = i_or_d_q;
  assign bus.ir_write      = fetch_ack;
  // Fetch PC+4 update waits for mem_ready; the branch is taken on the live flag.
  assign bus.pc_write      = pc_write_q | fetch_ack |
                             ((state == S_BRANCH) & bus.alu_leu);
  assign bus.reg_write     = reg_write_q;
  assign bus.mem_to_reg    = mem_to_reg_q;
  assign bus.reg_dst       = reg_dst_q;
  assign bus.alu_src_a     = alu_src_a_q;
  assign bus.alu_src_b     = alu_src_b_q;
  assign bus.alu_control   = ALU_W'(alu_op_q);
  assign bus.pc_src        = pc_src_q;
  assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle stimulus and expected
// outputs are queued per instruction, then replayed and compared cycle by cycle.
module tb_multicycle_control;
  import mctl_pkg::*;

  localparam int INS_W = 32;
  localparam int ALU_W = 5;
  localparam int CNT_W = 4;

  typedef struct {
    logic [INS_W-1:0] ins;
    logic             rdy;
    logic             leu;
    logic             rst;
    logic [17:0]      vec;
    logic [CNT_W-1:0] cnt;
    logic             ill;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  rec_t  q[$];
  string tq[$];
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_ill = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_if #(.INS_W(INS_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) bus ();

  multicycle_control #(.INS_W(INS_W), .ALU_W(ALU_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, mem_to_reg,
  //  reg_dst, alu_src_b, alu_control, pc_src}
  function automatic logic [17:0] ev(input logic mreq, mw, iord, irw, pcw, rw, m2r,
                                     input logic [1:0] rdst, asb,
                                     input logic [4:0] alu, input logic [1:0] pcs);
    return {mreq, mw, iord, irw, pcw, rw, m2r, rdst, asb, alu, pcs};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.mem_req, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.alu_src_b,
            bus.alu_control, bus.pc_src};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input string tag, input logic [INS_W-1:0] ins,
                      input logic rdy, input logic leu, input logic rst,
                      input logic [17:0] v);
    rec_t r;
    r.ins = ins; r.rdy = rdy; r.leu = leu; r.rst = rst; r.vec = v;
    r.cnt = m_cnt; r.ill = m_ill;
    q.push_back(r);
    tq.push_back(tag);
  endtask

  // Cycle after reset is released: idle FETCH, mem_ready must be ignored.
  task automatic push_post_reset(input logic [INS_W-1:0] ins);
    m_cnt = '0;
    m_ill = 1'b0;
    push("POSTRST", ins, 1'b1, rb(), 1'b0, '0);
  endtask

  task automatic push_fetch_decode(input logic [INS_W-1:0] ins, input int fw);
    for (int i = 0; i < fw; i++)
      push("FETCHW", ins, 1'b0, rb(), 1'b0, ev(1,0,0,0,0,0,0,2'd0,2'd1,ALU_ADD,2'd0));
    push("FETCH", ins, 1'b1, rb(), 1'b0, ev(1,0,0,1,1,0,0,2'd0,2'd1,ALU_ADD,2'd0));
    push("DECODE", ins, rb(), rb(), 1'b0, '0);
  endtask

  task automatic issue(input logic [5:0] op, input int fw, input int mw, input logic leu);
    logic [INS_W-1:0] ins;
    logic [4:0]       aop;
    logic             nori;
    ins  = {op, 26'($urandom)};
    nori = (op == OP_NORI);
    aop  = ALU_ADD;
    push_fetch_decode(ins, fw);
    case (op)
      OP_LW, OP_SW: begin
        push("MEMADDR", ins, rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,2'd0,2'd2,ALU_ADD,2'd0));
        if (op == OP_LW) begin
          for (int i = 0; i < mw; i++)
            push("MEMRDW", ins, 1'b0, rb(), 1'b0, ev(1,0,1,0,0,0,0,2'd0,2'd0,ALU_ADD,2'd0));
          push("MEMRD", ins, 1'b1, rb(), 1'b0, ev(1,0,1,0,0,0,0,2'd0,2'd0,ALU_ADD,2'd0));
          push("MEMWB", ins, rb(), rb(), 1'b0, ev(0,0,0,0,0,1,1,2'd0,2'd0,ALU_ADD,2'd0));
        end else begin
          for (int i = 0; i < mw; i++)
            push("MEMWRW", ins, 1'b0, rb(), 1'b0, ev(1,1,1,0,0,0,0,2'd0,2'd0,ALU_ADD,2'd0));
          push("MEMWR", ins, 1'b1, rb(), 1'b0, ev(1,1,1,0,0,0,0,2'd0,2'd0,ALU_ADD,2'd0));
        end
        m_cnt++;
      end
      OP_ANDR, OP_NORR, OP_NORI, OP_NOTR, OP_ROLV, OP_RORV: begin
        case (op)
          OP_ANDR: aop = ALU_AND;
          OP_ROLV: aop = ALU_ROL;
          OP_RORV: aop = ALU_ROR;
          default: aop = ALU_NOR;
        endcase
        push("EXEC", ins, rb(), rb(), 1'b0,
             ev(0,0,0,0,0,0,0,2'd0, nori ? 2'd2 : 2'd0, aop, 2'd0));
        push("ALUWB", ins, rb(), rb(), 1'b0,
             ev(0,0,0,0,0,1,0, nori ? 2'd0 : 2'd1, 2'd0, ALU_ADD, 2'd0));
        m_cnt++;
      end
      OP_BLEU: begin
        push("BRANCH", ins, rb(), leu, 1'b0, ev(0,0,0,0,leu,0,0,2'd0,2'd0,ALU_CMP_LEU,2'd1));
        m_cnt++;
      end
      OP_JR: begin
        push("JR", ins, rb(), rb(), 1'b0, ev(0,0,0,0,1,0,0,2'd0,2'd0,ALU_ADD,2'd3));
        m_cnt++;
      end
      OP_JAL: begin
        push("JAL", ins, rb(), rb(), 1'b0, ev(0,0,0,0,1,1,0,2'd2,2'd0,ALU_ADD,2'd2));
        m_cnt++;
      end
      default: begin
`ifdef MCTL_ILLEGAL_TRAP_EN
        m_ill = 1'b1;
        for (int i = 0; i < 3; i++)
          push("TRAP", ins, rb(), rb(), 1'b0, '0);
        push("TRAPRST", ins, rb(), rb(), 1'b1, '0);
        push_post_reset(ins);
`else
        m_cnt++;
`endif
      end
    endcase
  endtask

  // lw whose read is interrupted by reset while waiting in MEMREAD.
  task automatic issue_lw_reset();
    logic [INS_W-1:0] ins;
    ins = {OP_LW, 26'($urandom)};
    push_fetch_decode(ins, 0);
    push("MEMADDR", ins, rb(), rb(), 1'b0, ev(0,0,0,0,0,0,0,2'd0,2'd2,ALU_ADD,2'd0));
    push("MEMRDW", ins, 1'b0, rb(), 1'b0, ev(1,0,1,0,0,0,0,2'd0,2'd0,ALU_ADD,2'd0));
    push("MEMRDRST", ins, 1'b0, rb(), 1'b1, ev(1,0,1,0,0,0,0,2'd0,2'd0,ALU_ADD,2'd0));
    push_post_reset(ins);
  endtask

  initial begin
    rec_t  r;
    string tag;
    logic [5:0] alu_ops [6];
    alu_ops = '{OP_ANDR, OP_NORR, OP_NORI, OP_NOTR, OP_ROLV, OP_RORV};

    reset         = 1'b1;
    bus.ins       = '0;
    bus.mem_ready = 1'b0;
    bus.alu_leu   = 1'b0;
    repeat (2) @(posedge clk);

    push("RESET", '0, 1'b0, 1'b0, 1'b1, '0);
    push_post_reset('0);
    issue(OP_LW,   0, 0, 1'b0);
    issue(OP_SW,   0, 3, 1'b0);
    issue(OP_BLEU, 0, 0, 1'b1);
    issue(OP_BLEU, 1, 0, 1'b0);
    issue(OP_JAL,  0, 0, 1'b0);
    issue(OP_JR,   2, 0, 1'b0);
    foreach (alu_ops[i]) issue(alu_ops[i], 0, 0, 1'b0);
    // Mixed traffic long enough to wrap the 4-bit retired counter.
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0:       issue(OP_LW, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        1:       issue(OP_SW, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        default: issue(alu_ops[$urandom_range(0, 5)], 1, 0, 1'b0);
      endcase
    end
    issue(6'b111111, 0, 0, 1'b0);
    issue(OP_JR, 0, 0, 1'b0);
    issue_lw_reset();
    issue(OP_LW, 0, 1, 1'b0);
    issue(OP_BLEU, 0, 0, 1'b1);

    while (q.size() != 0) begin
      r   = q.pop_front();
      tag = tq.pop_front();
      @(posedge clk);
      #1;
      bus.ins       = r.ins;
      bus.mem_ready = r.rdy;
      bus.alu_leu   = r.leu;
      reset         = r.rst;
      @(negedge clk);
      check_val({tag, ".out"}, 32'(obs_vec()), 32'(r.vec));
      check_val({tag, ".cnt"}, 32'(bus.instr_retired), 32'(r.cnt));
      check_val({tag, ".ill"}, 32'(bus.illegal_op), 32'(r.ill));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
